// File: rtl/operand_fetch.sv
// operand_fetch: issue stage with pending-write scoreboard, writeback forwarding and one-entry output register
module operand_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rs0,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rd,
  input  logic        in_wen,
  output logic [4:0]  r_reg0,
  output logic [4:0]  r_reg1,
  input  logic [31:0] r_dat0,
  input  logic [31:0] r_dat1,
  input  logic        wb_valid,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_dat,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_op0,
  output logic [31:0] out_op1,
  output logic [4:0]  out_rd,
  output logic        out_wen
);
  logic [31:0] pending_q, pending_d;
  logic        out_valid_q, out_valid_d, out_wen_q, out_wen_d;
  logic [31:0] out_op0_q, out_op0_d, out_op1_q, out_op1_d;
  logic [4:0]  out_rd_q, out_rd_d;
  logic        fwd0, fwd1, fwdd, haz0, haz1, hazd, stall, acc, set_rd;
  assign r_reg0 = in_rs0;
  assign r_reg1 = in_rs1;
  always_comb begin
    fwd0 = wb_valid && wb_reg == in_rs0;
    fwd1 = wb_valid && wb_reg == in_rs1;
    fwdd = wb_valid && wb_reg == in_rd;
    haz0 = in_rs0 != 5'd0 && pending_q[in_rs0] && !fwd0;
    haz1 = in_rs1 != 5'd0 && pending_q[in_rs1] && !fwd1;
    hazd = in_wen && in_rd != 5'd0 && pending_q[in_rd] && !fwdd;
    stall = haz0 || haz1 || hazd;
    in_ready = !rst && !stall && (!out_valid_q || out_ready);
    acc = in_valid && in_ready;
    set_rd = acc && in_wen && in_rd != 5'd0;
    out_valid_d = acc ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
    out_op0_d = !acc ? out_op0_q : (in_rs0 == 5'd0 ? 32'd0 : (fwd0 ? wb_dat : r_dat0));
    out_op1_d = !acc ? out_op1_q : (in_rs1 == 5'd0 ? 32'd0 : (fwd1 ? wb_dat : r_dat1));
    out_rd_d = acc ? in_rd : out_rd_q;
    out_wen_d = acc ? (in_wen && in_rd != 5'd0) : out_wen_q;
    // set after clear so a same-index writeback never drops a fresh reservation
    pending_d = pending_q;
    if (wb_valid) pending_d[wb_reg] = 1'b0;
    if (set_rd) pending_d[in_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      out_valid_q <= 1'b0;
      out_op0_q <= '0;
      out_op1_q <= '0;
      out_rd_q <= '0;
      out_wen_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      out_valid_q <= out_valid_d;
      out_op0_q <= out_op0_d;
      out_op1_q <= out_op1_d;
      out_rd_q <= out_rd_d;
      out_wen_q <= out_wen_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_op0 = out_op0_q;
  assign out_op1 = out_op1_q;
  assign out_rd = out_rd_q;
  assign out_wen = out_wen_q;
endmodule

// File: doc/operand_fetch.md
# operand_fetch

Issue-side initiator for the two-read/one-write register file: accepts decoded instructions, drives the register-file read addresses, captures operands with writeback forwarding, and hands them to execute through a one-entry output register. A 32-entry pending-write scoreboard stalls issue on RAW and WAW hazards against in-flight writes, so the register file never needs interlocks of its own. Sits between decode and execute; the writeback stage's write port feeds both the register file and this block.

## Interface
- No parameters; widths fixed: 5-bit register index, 32-bit data.
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  block accepts the instruction this cycle
- in_rs0, in_rs1  in  5 each  source register indices
- in_rd  in  5  destination register index
- in_wen  in  1  instruction writes in_rd
- r_reg0, r_reg1  out  5 each  register-file read addresses
- r_dat0, r_dat1  in  32 each  register-file read data, combinational from r_reg0/r_reg1
- wb_valid  in  1  writeback writes this cycle (same signal as the register-file write enable)
- wb_reg  in  5  writeback destination
- wb_dat  in  32  writeback data
- out_valid  out  1  operands valid for execute
- out_ready  in  1  execute accepts
- out_op0, out_op1  out  32 each  captured operands
- out_rd  out  5  destination index
- out_wen  out  1  write flag, forced 0 when rd is 0

## Operation
- r_reg0 = in_rs0, r_reg1 = in_rs1, always, independent of valid.
- pending[31:0] scoreboard; bit 0 is constant 0.
- Hazard for source s (s != 0): pending[s] and not (wb_valid and wb_reg == s).
- Hazard for destination: in_wen and in_rd != 0 and pending[in_rd] and not (wb_valid and wb_reg == in_rd).
- stall = any hazard; in_ready = !rst and !stall and (!out_valid or out_ready).
- Accept = in_valid and in_ready. On accept, output register loads:
  - opN = 0 if rsN == 0; else wb_dat if wb_valid and wb_reg == rsN; else r_datN.
  - out_rd = in_rd; out_wen = in_wen and in_rd != 0; out_valid = 1.
- Without accept: out_valid clears on out_ready; otherwise holds, and the output fields stay stable.
- Scoreboard update per cycle: clear pending[wb_reg] if wb_valid, then set pending[in_rd] if accept and in_wen and in_rd != 0. When both hit the same index, set wins.
- wb_valid with wb_reg == 0 or with a non-pending index: no scoreboard effect, no error.

## Timing
- Reset: out_valid = 0, out_op0 = out_op1 = 0, out_rd = 0, out_wen = 0, pending = 0. in_ready = 0 while rst is high.
- Latency: accepted at edge N, visible on out_* after edge N (one cycle). Throughput is 1 per cycle when out_ready is held high and no hazards occur.
- in_ready is combinational from in_*, wb_*, out_ready and state. No combinational path from in_valid to in_ready.
- Forwarding resolves a same-cycle writeback, so a dependent instruction issues in the cycle its producer writes back, with zero bubble beyond the producer's latency.
- Reset mid-stream drops the held output and all pending bits. Writebacks arriving in the rst cycle are ignored.

## Test plan
- Reset, then issue rs0=3, rs1=4 with regfile x3=0x11, x4=0x22 and out_ready=1. Required: in_ready=1; one cycle later out_valid=1, out_op0=0x11, out_op1=0x22.
- Issue a writer rd=5 (in_wen=1), then a reader with rs0=5. Required: the reader stalls (in_ready=0) while pending[5] is set. In the cycle wb_valid=1, wb_reg=5, wb_dat=0xDEAD, the reader is accepted and the next cycle shows out_op0=0xDEAD.
- Issue rd=0 with in_wen=1, then rs0=0. Required: no stall, out_wen=0, out_op0=0, even if r_dat0=0xFFFFFFFF is driven.
- Hold out_ready=0 with out_valid=1 and a second instruction at in_valid=1. Required: in_ready=0, out_* unchanged for 3 cycles. Raising out_ready accepts the second instruction in that cycle.
- With pending[7] set, issue a new writer rd=7 in the same cycle as wb_reg=7. Required: the writer is accepted and pending[7] remains 1 afterwards.
- Assert rst with out_valid=1 and pending[9] set. Required: the next cycle has out_valid=0 and pending=0, and a reader of x9 issues with no stall.
